// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the EX stage: shift-add multiply and
// restoring divide, one bit per cycle, with a one-cycle fast path for divide corner cases.
module ex_muldiv_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start,
  input  logic            flush,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic [4:0]      rd_in,
  output logic            stall_req,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out
);

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_e;

  localparam logic [2:0] F_MUL    = 3'b000;
  localparam logic [2:0] F_MULH   = 3'b001;
  localparam logic [2:0] F_MULHSU = 3'b010;
  localparam logic [2:0] F_MULHU  = 3'b011;
  localparam logic [2:0] F_DIV    = 3'b100;
  localparam logic [2:0] F_DIVU   = 3'b101;
  localparam logic [2:0] F_REM    = 3'b110;
  localparam logic [2:0] F_REMU   = 3'b111;

  function automatic logic [XLEN-1:0] abs_if(input logic [XLEN-1:0] v, input logic en);
    abs_if = (en && v[XLEN-1]) ? (~v + XLEN'(1)) : v;
  endfunction

  state_e              state_q, state_d;
  logic [2:0]          f3_q, f3_d;
  logic [4:0]          rd_q, rd_d;
  logic [XLEN-1:0]     res_q, res_d;
  logic                done_q;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                neg_q, neg_d;
  logic [XLEN-1:0]     a_q, a_d, b_q, b_d, quo_q, quo_d;
  logic [2*XLEN-1:0]   acc_q, acc_d;
  logic [XLEN:0]       rem_q, rem_d;

  logic                sgn_a_s, sgn_b_s, is_div_s, div_zero_s, ovf_s;
  logic [XLEN-1:0]     a_abs_s, b_abs_s, mul_add_s, rest_lo_s, quo_next_s, rem_fin_s;
  logic [XLEN-1:0]     quo_sgn_s, rem_sgn_s;
  logic [XLEN:0]       mul_sum_s, shifted_s, diff_s;
  logic [2*XLEN-1:0]   mul_next_s, prod_sgn_s;

  assign sgn_a_s    = (funct3 == F_MULH) || (funct3 == F_MULHSU) || (funct3 == F_DIV) || (funct3 == F_REM);
  assign sgn_b_s    = (funct3 == F_MULH) || (funct3 == F_DIV) || (funct3 == F_REM);
  assign is_div_s   = funct3[2];
  assign div_zero_s = (op_b == {XLEN{1'b0}});
  assign ovf_s      = ((funct3 == F_DIV) || (funct3 == F_REM)) &&
                      (op_a == {1'b1, {(XLEN-1){1'b0}}}) && (op_b == {XLEN{1'b1}});
  assign a_abs_s    = abs_if(op_a, sgn_a_s);
  assign b_abs_s    = abs_if(op_b, sgn_b_s);

  // Multiplier sits in the low half of acc and is consumed LSB first.
  assign mul_add_s  = acc_q[0] ? a_q : {XLEN{1'b0}};
  assign mul_sum_s  = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, mul_add_s};
  assign mul_next_s = {mul_sum_s, acc_q[XLEN-1:1]};

  // A negative trial remainder (top bit set) is restored before the next shift.
  assign rest_lo_s  = rem_q[XLEN] ? (rem_q[XLEN-1:0] + b_q) : rem_q[XLEN-1:0];
  assign shifted_s  = {rest_lo_s, quo_q[XLEN-1]};
  assign diff_s     = shifted_s - {1'b0, b_q};
  assign quo_next_s = {quo_q[XLEN-2:0], ~diff_s[XLEN]};
  assign rem_fin_s  = diff_s[XLEN] ? shifted_s[XLEN-1:0] : diff_s[XLEN-1:0];

  assign prod_sgn_s = neg_q ? (~mul_next_s + (2*XLEN)'(1)) : mul_next_s;
  assign quo_sgn_s  = neg_q ? (~quo_next_s + XLEN'(1)) : quo_next_s;
  assign rem_sgn_s  = neg_q ? (~rem_fin_s + XLEN'(1)) : rem_fin_s;

  // Next-state, operand capture, iteration and result select.
  always_comb begin
    state_d = state_q;
    f3_d    = f3_q;
    rd_d    = rd_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    neg_d   = neg_q;
    a_d     = a_q;
    b_d     = b_q;
    quo_d   = quo_q;
    acc_d   = acc_q;
    rem_d   = rem_q;
    if (flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            f3_d  = funct3;
            rd_d  = rd_in;
            a_d   = a_abs_s;
            b_d   = b_abs_s;
            quo_d = a_abs_s;
            acc_d = {{XLEN{1'b0}}, b_abs_s};
            rem_d = {(XLEN+1){1'b0}};
            cnt_d = {CNT_W{1'b0}};
            neg_d = (sgn_a_s & op_a[XLEN-1]) ^ (sgn_b_s & (funct3 != F_REM) & op_b[XLEN-1]);
            if (is_div_s && div_zero_s) begin
              res_d   = funct3[1] ? op_a : {XLEN{1'b1}};
              state_d = DONE;
            end else if (ovf_s) begin
              res_d   = funct3[1] ? {XLEN{1'b0}} : {1'b1, {(XLEN-1){1'b0}}};
              state_d = DONE;
            end else begin
              state_d = CALC;
            end
          end else begin
            state_d = IDLE;
          end
        end
        CALC: begin
          cnt_d = cnt_q + CNT_W'(1);
          acc_d = mul_next_s;
          quo_d = quo_next_s;
          rem_d = diff_s;
          if (cnt_q == CNT_W'(XLEN-1)) begin
            state_d = DONE;
            case (f3_q)
              F_MUL:    res_d = prod_sgn_s[XLEN-1:0];
              F_MULH,
              F_MULHSU,
              F_MULHU:  res_d = prod_sgn_s[2*XLEN-1:XLEN];
              F_DIV:    res_d = quo_sgn_s;
              F_DIVU:   res_d = quo_next_s;
              F_REM:    res_d = rem_sgn_s;
              F_REMU:   res_d = rem_fin_s;
              default:  res_d = res_q;
            endcase
          end else begin
            state_d = CALC;
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      f3_q    <= 3'd0;
      rd_q    <= 5'd0;
      res_q   <= {XLEN{1'b0}};
      done_q  <= 1'b0;
      cnt_q   <= {CNT_W{1'b0}};
      neg_q   <= 1'b0;
      a_q     <= {XLEN{1'b0}};
      b_q     <= {XLEN{1'b0}};
      quo_q   <= {XLEN{1'b0}};
      acc_q   <= {(2*XLEN){1'b0}};
      rem_q   <= {(XLEN+1){1'b0}};
    end else begin
      state_q <= state_d;
      f3_q    <= f3_d;
      rd_q    <= rd_d;
      res_q   <= res_d;
      done_q  <= (state_d == DONE);
      cnt_q   <= cnt_d;
      neg_q   <= neg_d;
      a_q     <= a_d;
      b_q     <= b_d;
      quo_q   <= quo_d;
      acc_q   <= acc_d;
      rem_q   <= rem_d;
    end
  end

  assign stall_req = reset_n && (((state_q == IDLE) && start && !flush) || (state_q == CALC));
  assign done      = done_q;
  assign result    = res_q;
  assign rd_out    = rd_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit: directed corner cases, flush/reset
// scenarios and randomized ops against an arithmetic reference model.
module tb_ex_muldiv_unit;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic        flush;
  logic [2:0]  funct3;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [4:0]  rd_in;
  logic        stall_req;
  logic        done;
  logic [31:0] result;
  logic [4:0]  rd_out;

  int          errors = 0;
  int          checks = 0;
  logic        exp_pending = 1'b0;
  logic [31:0] exp_result = 32'd0;
  logic [4:0]  exp_rd = 5'd0;

  ex_muldiv_unit #(.XLEN(32), .CNT_W(6)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .flush(flush), .funct3(funct3),
    .op_a(op_a), .op_b(op_b), .rd_in(rd_in), .stall_req(stall_req), .done(done),
    .result(result), .rd_out(rd_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // RV32M semantics from plain integer arithmetic.
  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    int ia, ib;
    longint sa, sb, ub;
    logic [63:0] p;
    ia = a; ib = b; sa = ia; sb = ib; ub = longint'({32'd0, b});
    case (f)
      3'd0: begin p = 64'(sa * sb); return p[31:0]; end
      3'd1: begin p = 64'(sa * sb); return p[63:32]; end
      3'd2: begin p = 64'(sa * ub); return p[63:32]; end
      3'd3: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
      3'd4: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        else return 32'(ia / ib);
      end
      3'd5: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        else return a / b;
      end
      3'd6: begin
        if (b == 32'd0) return a;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        else return 32'(ia % ib);
      end
      3'd7: begin
        if (b == 32'd0) return a;
        else return a % b;
      end
      default: return 32'd0;
    endcase
  endfunction

  function automatic int exp_stalls(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (f[2] && (b == 32'd0 || ((f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)))
      return 1;
    else
      return 33;
  endfunction

  // Compare process: every done pulse must match the pending expectation.
  always @(negedge clk) begin
    if (reset_n && done) begin
      if (!exp_pending) begin
        chk("unexpected_done", {63'd0, done}, 64'd0);
      end else begin
        chk("result", result, exp_result);
        chk("rd_out", rd_out, exp_rd);
        chk("stall_in_done", {63'd0, stall_req}, 64'd0);
        exp_pending = 1'b0;
      end
    end
  end

  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    int  stalls;
    bit  seen;
    exp_result  = model(f, a, b);
    exp_rd      = rd;
    exp_pending = 1'b1;
    funct3 = f; op_a = a; op_b = b; rd_in = rd; start = 1'b1;
    stalls = 0; seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (stall_req) stalls++;
      if (done) seen = 1'b1;
      @(posedge clk); #1;
    end
    start = 1'b0;
    chk("done_seen", {63'd0, seen}, 64'd1);
    chk("stall_cycles", 64'(stalls), 64'(exp_stalls(f, a, b)));
    exp_pending = 1'b0;
    @(negedge clk);
    chk("done_one_cycle", {63'd0, done}, 64'd0);
    @(posedge clk); #1;
  endtask

  task automatic pin_run(input string nm, input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] lit);
    chk({"model_", nm}, model(f, a, b), lit);
    run_op(f, a, b, 5'(f) + 5'd3);
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b1; flush = 1'b0;
    funct3 = 3'd0; op_a = 32'd7; op_b = 32'd3; rd_in = 5'd9;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_stall", {63'd0, stall_req}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_result", result, 64'd0);
    chk("rst_rd", rd_out, 64'd0);
    start = 1'b0;
    reset_n = 1'b1;
    @(posedge clk); #1;

    pin_run("mul",     3'd0, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB);
    pin_run("mulhu",   3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    pin_run("mulh",    3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000);
    pin_run("mulhsu",  3'd2, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF);
    pin_run("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    pin_run("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000);
    pin_run("divu_z",  3'd5, 32'd5,         32'd0,         32'hFFFF_FFFF);
    pin_run("remu_z",  3'd7, 32'd5,         32'd0,         32'd5);
    pin_run("div_neg", 3'd4, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD);
    pin_run("rem_neg", 3'd6, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF);
    pin_run("divu",    3'd5, 32'hFFFF_FFF9, 32'd2,         32'h7FFF_FFFC);

    // Flush ten cycles into CALC: nothing may be produced.
    funct3 = 3'd0; op_a = 32'd5; op_b = 32'd6; rd_in = 5'd17; start = 1'b1;
    @(posedge clk); #1;
    repeat (10) @(posedge clk);
    #1;
    chk("calc_stall", {63'd0, stall_req}, 64'd1);
    start = 1'b0; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_stall", {63'd0, stall_req}, 64'd0);
    chk("flush_done", {63'd0, done}, 64'd0);
    repeat (40) @(posedge clk);
    #1;
    pin_run("mul_small", 3'd0, 32'd3, 32'd4, 32'd12);

    // Flush together with start in IDLE launches nothing.
    funct3 = 3'd5; op_a = 32'd9; op_b = 32'd2; start = 1'b1; flush = 1'b1;
    #1;
    chk("flush_start_stall", {63'd0, stall_req}, 64'd0);
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    chk("flush_start_idle", {63'd0, stall_req}, 64'd0);
    repeat (40) @(posedge clk);
    #1;

    // Asynchronous reset five cycles into CALC.
    funct3 = 3'd5; op_a = 32'd100; op_b = 32'd7; rd_in = 5'd21; start = 1'b1;
    @(posedge clk); #1;
    repeat (5) @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_stall", {63'd0, stall_req}, 64'd0);
    chk("arst_done", {63'd0, done}, 64'd0);
    chk("arst_result", result, 64'd0);
    @(posedge clk); #1;
    start = 1'b0; reset_n = 1'b1;
    @(posedge clk); #1;
    pin_run("divu_post", 3'd5, 32'd100, 32'd7, 32'd14);
    pin_run("remu_post", 3'd7, 32'd100, 32'd7, 32'd2);

    for (int n = 0; n < 150; n++) begin
      logic [31:0] ra, rb;
      case ($urandom_range(0, 7))
        0:       ra = 32'd0;
        1:       ra = 32'hFFFF_FFFF;
        2:       ra = 32'h8000_0000;
        3:       ra = $urandom_range(0, 20);
        default: ra = $urandom;
      endcase
      case ($urandom_range(0, 7))
        0:       rb = 32'd0;
        1:       rb = 32'hFFFF_FFFF;
        2:       rb = 32'h8000_0000;
        3:       rb = $urandom_range(0, 20);
        default: rb = $urandom;
      endcase
      run_op(3'($urandom_range(0, 7)), ra, rb, 5'($urandom_range(0, 31)));
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
